// File: rtl/dot_product_pkg.sv
// -----------------------------------------------------------------------------
// dot_product_pkg
// Shared definitions for the dot-product MAC:
//   - state_e      : controller states (2-bit encoding)
//   - clog2        : ceiling log2 usable in constant expressions
//   - idx_w        : element index width (at least 1 bit)
//   - prod_w       : width of a signed A times zero-extended B product
//   - acc_w        : accumulator width that can hold N_ELEM products exactly
//   - sat_max/min  : signed limits of a w-bit result, returned LIM_W wide
// -----------------------------------------------------------------------------
package dot_product_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of the saturation limit helpers; OUT_W must not exceed this.
  localparam int LIM_W = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int idx_w(input int n_elem);
    return (clog2(n_elem) < 1) ? 1 : clog2(n_elem);
  endfunction

  // Signed A_W-bit times unsigned B_W-bit needs A_W+B_W+1 bits once B gets a sign bit.
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic int acc_w(input int a_w, input int b_w, input int n_elem);
    return prod_w(a_w, b_w) + clog2(n_elem);
  endfunction

  function automatic logic signed [LIM_W-1:0] sat_max(input int w);
    return (LIM_W'(1) <<< (w - 1)) - LIM_W'(1);
  endfunction

  function automatic logic signed [LIM_W-1:0] sat_min(input int w);
    return -(LIM_W'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/dot_product_mac_fxp_mul_stage.sv
// -----------------------------------------------------------------------------
// fxp_mul_stage
// Registered signed x unsigned multiply followed by an arithmetic right shift
// (floor rounding). One cycle latency, valid travels alongside the data.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid_i      operands on a_i/b_i are valid
//   a_i             signed multiplicand, A_W bits
//   b_i             unsigned multiplier, B_W bits
//   out_valid_o     prod_o is valid
//   prod_o          (a_i * b_i) >>> PROD_SHIFT, A_W+B_W+1 bits signed
// -----------------------------------------------------------------------------
module fxp_mul_stage #(
  parameter int A_W        = 19,
  parameter int B_W        = 10,
  parameter int PROD_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  input  logic [A_W-1:0]             a_i,
  input  logic [B_W-1:0]             b_i,
  output logic                       out_valid_o,
  output logic signed [A_W+B_W:0]    prod_o
);

  logic signed [A_W+B_W:0] full_prod;
  logic signed [A_W+B_W:0] prod_q;
  logic                    valid_q;

  // Zero-extend B so the multiply stays signed without misreading B's MSB.
  assign full_prod = $signed(a_i) * $signed({1'b0, b_i});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) prod_q <= full_prod >>> PROD_SHIFT;
    end
  end

  assign out_valid_o = valid_q;
  assign prod_o      = prod_q;

endmodule

// File: rtl/dot_product_mac.sv
// -----------------------------------------------------------------------------
// dot_product_mac
// Sequential dot product: sum over i of (A_i * B_i) >>> PROD_SHIFT, one element
// pair per cycle through a single pipelined multiplier, with valid/ready
// handshakes and saturate/wrap narrowing to OUT_W.
// Ports:
//   clk          clock (rising edge)
//   GlobalReset  asynchronous active-low reset
//   in_valid     operand vectors and mode_sat presented
//   in_ready     high in IDLE only
//   A_vec        N_ELEM signed A_W-bit elements, element i at [i*A_W +: A_W]
//   B_vec        N_ELEM unsigned B_W-bit elements, element i at [i*B_W +: B_W]
//   mode_sat     1 = saturate, 0 = wrap (sampled at acceptance)
//   out_valid    result available, held until out_ready
//   out_ready    consumer accepts the result
//   out_data     signed OUT_W-bit result
//   out_ovf      full-precision sum did not fit OUT_W
// -----------------------------------------------------------------------------
module dot_product_mac
  import dot_product_pkg::*;
#(
  parameter int N_ELEM     = 10,
  parameter int A_W        = 19,
  parameter int B_W        = 10,
  parameter int OUT_W      = 26,
  parameter int PROD_SHIFT = 3
) (
  input  logic                    clk,
  input  logic                    GlobalReset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_ELEM*A_W-1:0]   A_vec,
  input  logic [N_ELEM*B_W-1:0]   B_vec,
  input  logic                    mode_sat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_ovf
);

  localparam int IDX_W  = idx_w(N_ELEM);
  localparam int PROD_W = prod_w(A_W, B_W);
  localparam int ACC_W  = acc_w(A_W, B_W, N_ELEM);

  state_e                   state_q, state_d;
  logic [N_ELEM*A_W-1:0]    a_snap_q;
  logic [N_ELEM*B_W-1:0]    b_snap_q;
  logic                     mode_sat_q;
  logic [IDX_W-1:0]         idx_q;
  logic [A_W-1:0]           op_a_q;
  logic [B_W-1:0]           op_b_q;
  logic                     op_valid_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [OUT_W-1:0]         out_data_q;
  logic                     out_ovf_q;

  logic                     prod_valid;
  logic signed [PROD_W-1:0] prod;
  logic [A_W-1:0]           a_sel;
  logic [B_W-1:0]           b_sel;
  logic                     idx_last;
  logic                     accept;
  logic                     issue;
  logic                     pipe_empty;
  logic [OUT_W-1:0]         narrow_data;
  logic                     narrow_ovf;

  assign idx_last   = (idx_q == IDX_W'(N_ELEM - 1));
  assign accept     = (state_q == IDLE) && in_valid;
  assign issue      = (state_q == RUN);
  assign pipe_empty = !op_valid_q && !prod_valid;

  // Element select from the snapshot; compare-based so idx width need not
  // match the element count exactly.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_sel = a_snap_q[i*A_W +: A_W];
        b_sel = b_snap_q[i*B_W +: B_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (idx_last)   state_d = DRAIN;
      DRAIN:   if (pipe_empty) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  fxp_mul_stage #(
    .A_W       (A_W),
    .B_W       (B_W),
    .PROD_SHIFT(PROD_SHIFT)
  ) u_mul (
    .clk        (clk),
    .rst_n      (GlobalReset),
    .in_valid_i (op_valid_q),
    .a_i        (op_a_q),
    .b_i        (op_b_q),
    .out_valid_o(prod_valid),
    .prod_o     (prod)
  );

  // Narrowing: if OUT_W can already hold every accumulator value, just extend.
  generate
    if (OUT_W >= ACC_W) begin : g_no_narrow
      assign narrow_data = OUT_W'(acc_q);
      assign narrow_ovf  = 1'b0;
    end else begin : g_narrow
      localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(OUT_W));
      localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(OUT_W));
      logic hi, lo;
      assign hi         = (acc_q > ACC_MAX);
      assign lo         = (acc_q < ACC_MIN);
      assign narrow_ovf = hi || lo;
      always_comb begin
        narrow_data = acc_q[OUT_W-1:0];
        if (mode_sat_q && hi) narrow_data = ACC_MAX[OUT_W-1:0];
        if (mode_sat_q && lo) narrow_data = ACC_MIN[OUT_W-1:0];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state_q    <= IDLE;
      a_snap_q   <= '0;
      b_snap_q   <= '0;
      mode_sat_q <= 1'b0;
      idx_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_valid_q <= issue;
      if (accept) begin
        a_snap_q   <= A_vec;
        b_snap_q   <= B_vec;
        mode_sat_q <= mode_sat;
        idx_q      <= '0;
        acc_q      <= '0;
      end
      if (issue) begin
        op_a_q <= a_sel;
        op_b_q <= b_sel;
        // Hold at the last index rather than wrapping.
        if (!idx_last) idx_q <= idx_q + IDX_W'(1);
      end
      if (prod_valid) acc_q <= acc_q + ACC_W'(prod);
      if ((state_q == DRAIN) && pipe_empty) begin
        out_data_q <= narrow_data;
        out_ovf_q  <= narrow_ovf;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dot_product_mac.sv
module tb_dot_product_mac;

  localparam int N    = 10;
  localparam int AW   = 19;
  localparam int BW   = 10;
  localparam int OW   = 26;
  localparam int SH   = 3;

  logic            clk;
  logic            GlobalReset;
  logic            in_valid;
  logic            in_ready;
  logic [N*AW-1:0] A_vec;
  logic [N*BW-1:0] B_vec;
  logic            mode_sat;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic            out_ovf;

  typedef struct {
    logic [OW-1:0] data;
    logic          ovf;
  } exp_t;

  exp_t sb[$];
  int   a_arr[N];
  int   b_arr[N];
  int   checks = 0;
  int   errors = 0;

  dot_product_mac #(
    .N_ELEM(N), .A_W(AW), .B_W(BW), .OUT_W(OW), .PROD_SHIFT(SH)
  ) dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A_vec      (A_vec),
    .B_vec      (B_vec),
    .mode_sat   (mode_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int a, input int b_base, input int b_step);
    for (int i = 0; i < N; i++) begin
      a_arr[i] = a;
      b_arr[i] = b_base + b_step * i;
    end
  endtask

  // Reference: full-precision floor-shifted sum, then narrowing.
  task automatic push_expected(input logic sat);
    longint sum;
    longint p;
    longint maxv;
    longint minv;
    exp_t   e;
    sum  = 0;
    maxv = (longint'(1) <<< (OW - 1)) - 1;
    minv = -(longint'(1) <<< (OW - 1));
    for (int i = 0; i < N; i++) begin
      p   = longint'(a_arr[i]) * longint'(b_arr[i]);
      sum = sum + (p >>> SH);
    end
    e.ovf  = (sum > maxv) || (sum < minv);
    e.data = sum[OW-1:0];
    if (sat && sum > maxv) e.data = maxv[OW-1:0];
    if (sat && sum < minv) e.data = minv[OW-1:0];
    sb.push_back(e);
  endtask

  task automatic start_job(input logic sat);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_wait: in_ready=%b required 1", in_ready);
    end
    for (int i = 0; i < N; i++) begin
      A_vec[i*AW +: AW] = a_arr[i][AW-1:0];
      B_vec[i*BW +: BW] = b_arr[i][BW-1:0];
    end
    mode_sat = sat;
    in_valid = 1'b1;
    push_expected(sat);
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid (bounded), compares against the scoreboard, handshakes.
  task automatic collect(input string name, output int lat);
    exp_t e;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty: got data=%0d with no expectation", name, $signed(out_data));
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_data !== e.data || out_ovf !== e.ovf) begin
        errors++;
        $display("FAIL %s: data=%0d ovf=%b required data=%0d ovf=%b",
                 name, $signed(out_data), out_ovf, $signed(e.data), e.ovf);
      end else begin
        $display("job %s: data=%0d ovf=%b latency=%0d", name, $signed(out_data), out_ovf, lat);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    GlobalReset = 1'b0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%0d out_ovf=%b required 1 0 0 0",
               in_ready, out_valid, out_data, out_ovf);
    end else $display("reset: in_ready=1 out_valid=0 out_data=0 out_ovf=0");
    GlobalReset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    fill(8, 1, 1);
    start_job(1'b1);
    collect("basic", lat);
    // lat counts edges after the acceptance edge; first high sample is after edge T+13.
    checks++;
    if (lat !== 13) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d required 13", lat);
    end
  endtask

  task automatic test_rounding();
    int lat;
    fill(-8, 1, 0); start_job(1'b1); collect("neg8", lat);
    fill(-1, 1, 0); start_job(1'b1); collect("neg1_floor", lat);
    fill(1, 1, 0);  start_job(1'b1); collect("pos1_floor", lat);
    fill(-200000, 1000, 2); start_job(1'b0); collect("mixed", lat);
  endtask

  task automatic test_saturate();
    int lat;
    fill(262143, 1023, 0); start_job(1'b1); collect("sat_pos", lat);
    fill(-262144, 1023, 0); start_job(1'b1); collect("sat_neg", lat);
  endtask

  task automatic test_wrap();
    int lat;
    fill(262143, 1023, 0); start_job(1'b0); collect("wrap_pos", lat);
    fill(-262144, 1023, 0); start_job(1'b0); collect("wrap_neg", lat);
  endtask

  task automatic test_snapshot();
    int lat;
    fill(100, 3, 7);
    start_job(1'b0);
    tick();
    // Perturb every input mid-job; none of it may reach the result.
    A_vec    = '1;
    B_vec    = '1;
    mode_sat = 1'b1;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL snap_in_ready: in_ready=%b required 0", in_ready);
    end
    tick();
    tick();
    in_valid = 1'b0;
    collect("snapshot", lat);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   waited;
    fill(-5000, 900, 3);
    start_job(1'b1);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    e = sb[0];
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_ovf !== e.ovf) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b data=%0d ovf=%b required 1 %0d %b",
                 c, out_valid, $signed(out_data), out_ovf, $signed(e.data), e.ovf);
      end
      tick();
    end
    collect("backpressure", waited);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midjob();
    int lat;
    fill(300, 500, 0);
    start_job(1'b1);
    repeat (4) tick();
    GlobalReset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: out_valid=%b required 0", out_valid);
    end
    sb.delete();
    tick();
    GlobalReset = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end else $display("midreset: aborted, in_ready=1");
    fill(8, 1, 0);
    start_job(1'b1);
    collect("after_reset", lat);
  endtask

  initial begin
    GlobalReset = 1'b0;
    in_valid    = 1'b0;
    A_vec       = '0;
    B_vec       = '0;
    mode_sat    = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturate();
    test_wrap();
    test_snapshot();
    test_backpressure();
    test_reset_midjob();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
